seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Reads back a time-multiplexed, active-low seven-segment display bus (segment lines plus digit anodes) and reconstructs the hex word being shown. It is the inverse of the hex-to-segment ROM path. It watches the scan, waits for each digit's pattern to settle, decodes it to a nibble, and emits one `valid` pulse per complete frame. It sits on the display side of the design as a self-check or loopback monitor.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (2–8).
- `STABLE_CYC`, default 4: consecutive identical samples required before capture (≥2).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `seg`  in  7: segment lines, active-low; bit6=a … bit0=g.
- `an`  in  DIGITS: digit enables, active-low; `an[i]`=0 selects digit i.
- `value`  out  4*DIGITS: last complete frame; digit i in `value[4i+3:4i]`.
- `valid`  out  1: one-cycle pulse when `value`/`err` update.
- `err`  out  1: frame contained ≥1 unrecognised pattern; qualified by `valid`.
- `digit_mask`  out  DIGITS: digits captured so far in current frame.

## Operation
- Inputs registered once (`s_q`={an,seg}); a second register holds previous `s_q` for change detection.
- Patterns decoded (active-low, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. Any other pattern counts as invalid.
- FSM states:
  - SETTLE: `cnt` counts identical samples; any change in `s_q` clears `cnt` and stays in SETTLE. When `cnt`==STABLE_CYC-1 and `an` is one-hot-low, capture and go to HOLD.
  - HOLD: no further capture. Any change in `s_q` goes to SETTLE with `cnt`=0.
- `an` all-ones (blank) or more than one low: no capture, `cnt` held at 0, and the FSM stays in or returns to SETTLE.
- Capture of digit i:
  - Valid pattern: write the nibble to frame slot i and set `digit_mask[i]`.
  - Invalid pattern: write 0 to slot i, set `digit_mask[i]`, and set the sticky frame-error bit.
  - Re-capture of an already-masked digit overwrites its slot. The mask is unchanged.
- Frame completion: when the capture makes `digit_mask` all-ones, the next edge copies the slots to `value` and the frame-error bit to `err`, pulses `valid`, and clears the mask and frame-error bit.
  - A capture on the same edge as completion starts the new frame. Its mask bit survives the clear.
- `cnt` is $clog2(STABLE_CYC) bits. It saturates and never wraps.

## Timing
- Reset values: `value`=0, `valid`=0, `err`=0, `digit_mask`=0, FSM=SETTLE, `cnt`=0, error counter=0.
- `rst` mid-frame discards partial slots and mask. `value` returns to 0.
- Capture latency: `{an,seg}` constant from edge t gives capture on edge t+STABLE_CYC (one input-register stage plus STABLE_CYC-1 counts).
- `valid` asserts one edge after the final capture and lasts exactly one cycle. `value` and `err` hold until the next frame.
- A glitch of a single cycle restarts settling. Patterns shorter than STABLE_CYC samples are never captured.

## Configuration
- `SEG7_ERR_CNT_EN` defined: adds output `err_cnt` (8 bits). It increments on every invalid-pattern capture, saturates at 255, and is cleared only by `rst`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- `seg7_pkg`:
  - 16 segment-pattern constants;
  - FSM state enum (SETTLE, HOLD);
  - `SEG_W`=7.
- Sub-module `seg7_pattern_decode`: combinational, 7-bit pattern in, {hit, nibble} out. It uses the package constants so the encoder ROM and this decoder share one table.

## Test plan
- Scan an[0..3] with 3/A/0/F (0000110, 0001000, 0000001, 0111000), 8 cycles each -> `valid` pulse with `value`=16'hF0A3 and `err`=0. The pulse is 1 cycle after the digit-3 capture.
- Same scan, with digit 1 showing 1111111 -> `value`=16'hF003, `err`=1. `err_cnt`=1 when `SEG7_ERR_CNT_EN`.
- Dwell of 3 cycles with STABLE_CYC=4 -> no capture and `digit_mask` stays 0. A 1-cycle seg glitch inside an 8-cycle dwell -> a single capture, after re-settling.
- `an`=4'b1111 blanks and 4'b0011 interleaved between digits -> ignored; the frame still completes with the correct value.
- `rst` pulsed after 2 digits captured -> all outputs 0 and `digit_mask`=0. The next full scan of 1/2/3/4 gives `value`=16'h4321.
- Digit 0 re-shown with 7 then 9 before the frame completes -> `value[3:0]`=9, with a single `valid` pulse.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low a..g patterns for hex digits
// and the scan-decoder FSM state type.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

  // Indexed by nibble value; the encoder ROM and the decoder both read this.
  localparam logic [SEG_W-1:0] SEG_ROM [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment ROM: pattern in, {hit, nibble} out.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic             hit,
  output logic [3:0]       nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == SEG_ROM[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-seg bus and rebuilds the displayed hex word.
// Optional SEG7_ERR_CNT_EN adds a saturating 8-bit invalid-pattern counter (err_cnt).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEG_W-1:0]      seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic                  valid,
  output logic                  err,
  output logic [DIGITS-1:0]     digit_mask
`ifdef SEG7_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYC);
  localparam int unsigned S_W   = DIGITS + SEG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

  logic [S_W-1:0]           s_q;
  logic [S_W-1:0]           p_q;
  state_e                   state;
  logic [CNT_W-1:0]         cnt;
  logic [DIGITS-1:0][3:0]   slots;
  logic                     ferr;

  logic [DIGITS-1:0]        sel;
  logic                     one_hot;
  logic                     changed;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     capture;
  logic                     frame_done;
  logic                     hit;
  logic [3:0]               nib;
  logic [DIGITS-1:0]        mask_nxt;
  logic                     ferr_nxt;

  seg7_pattern_decode u_decode (
    .pattern (s_q[SEG_W-1:0]),
    .hit     (hit),
    .nibble  (nib)
  );

  // Settle/capture qualification and next frame bookkeeping.
  always_comb begin
    sel        = ~s_q[S_W-1:SEG_W];
    one_hot    = $onehot(sel);
    changed    = (s_q != p_q);
    cnt_nxt    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    capture    = (state == SETTLE) && one_hot && !changed && (cnt_nxt == CNT_MAX);
    frame_done = &digit_mask;
    mask_nxt   = frame_done ? '0 : digit_mask;
    ferr_nxt   = frame_done ? 1'b0 : ferr;
    if (capture) begin
      mask_nxt = mask_nxt | sel;
      ferr_nxt = ferr_nxt | ~hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= '1;
      p_q        <= '1;
      state      <= SETTLE;
      cnt        <= '0;
      slots      <= '0;
      ferr       <= 1'b0;
      digit_mask <= '0;
      value      <= '0;
      valid      <= 1'b0;
      err        <= 1'b0;
    end else begin
      s_q        <= {an, seg};
      p_q        <= s_q;
      valid      <= 1'b0;
      digit_mask <= mask_nxt;
      ferr       <= ferr_nxt;

      if (!one_hot || changed) begin
        state <= SETTLE;
        cnt   <= '0;
      end else if (state == SETTLE) begin
        cnt <= cnt_nxt;
        if (capture) state <= HOLD;
      end

      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (capture && sel[i]) slots[i] <= hit ? nib : 4'h0;
      end

      // Completion uses the pre-capture slots; a same-edge capture opens the next frame.
      if (frame_done) begin
        value <= slots;
        err   <= ferr;
        valid <= 1'b1;
      end
    end
  end

`ifdef SEG7_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (capture && !hit && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
